// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO and launch controller feeding the UART transmitter. Host bytes
//   are buffered in a circular buffer; one byte at a time is popped, presented
//   on tx_data_in with a single-cycle tx_start, and the next launch waits for
//   tx_done from the transmitter.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   wr_en      : host push strobe (one byte per cycle)
//   wr_data    : host byte
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : number of stored bytes
//   drop       : one-cycle pulse after a push rejected because full
//   tx_start   : one-cycle launch pulse to the transmitter
//   tx_data_in : byte presented to the transmitter, held from launch to tx_done
//   tx_busy    : transmitter busy (gates launches from IDLE only)
//   tx_done    : transmitter completion pulse
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  drop,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_busy,
  input  logic                  tx_done
);

  typedef enum logic {
    IDLE,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_drop;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;

  state_t r_state;
  state_t w_state_next;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  // A full FIFO rejects the push even if a pop frees a slot this same cycle.
  assign w_push  = wr_en && !w_full;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_pop)   w_state_next = WAIT_DONE;
      WAIT_DONE: if (tx_done) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // FSM: output decode; tx_busy matters only when deciding to launch
  always_comb begin
    w_pop = 1'b0;
    if (r_state == IDLE) begin
      w_pop = !w_empty && !tx_busy;
    end
  end

  // Storage array is not reset; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_drop     <= wr_en && w_full;
      // Pop only happens from IDLE, so the pulse drops on the next cycle.
      r_tx_start <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign drop       = r_drop;
  assign tx_start   = r_tx_start;
  assign tx_data_in = r_tx_data;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. The bench itself plays the transmitter
//   (tx_busy / tx_done) and a negedge monitor records every launched byte.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       drop;
  logic       tx_start;
  logic [7:0] tx_data_in;
  logic       tx_busy;
  logic       tx_done;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  launched [$];
  int unsigned n_before;

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .empty(empty),
    .count(count),
    .drop(drop),
    .tx_start(tx_start),
    .tx_data_in(tx_data_in),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Each high-level sample of tx_start is one launch.
  always @(negedge clk) begin
    if (tx_start === 1'b1) launched.push_back(tx_data_in);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmitter stand-in: busy for n cycles after a launch, then tx_done.
  task automatic frame(input logic [7:0] exp, input int unsigned n);
    tx_busy = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      tick;
      chk("start_width", tx_start, 1'b0);
      chk("data_hold", tx_data_in, exp);
    end
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick;
    chk("data_hold_done", tx_data_in, exp);
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_busy = 1'b0; tx_done = 1'b0;

    // 1. reset values with wr_en toggling
    for (int unsigned i = 0; i < 5; i++) begin
      wr_en   = i[0];
      wr_data = 8'hE0 + 8'(i);
      tick;
      chk("rst_count", count, 5'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_start", tx_start, 1'b0);
      chk("rst_data", tx_data_in, 8'h00);
      chk("rst_drop", drop, 1'b0);
    end
    rst = 1'b0; wr_en = 1'b0;
    tick;

    // 2. single byte
    wr_en = 1'b1; wr_data = 8'hAB;
    tick;
    chk("single_count", count, 5'd1);
    chk("single_empty", empty, 1'b0);
    chk("single_start_early", tx_start, 1'b0);
    wr_en = 1'b0;
    tick;
    chk("single_start", tx_start, 1'b1);
    chk("single_data", tx_data_in, 8'hAB);
    chk("single_count_pop", count, 5'd0);
    frame(8'hAB, 3);
    tick;
    chk("single_no_relaunch", tx_start, 1'b0);
    chk("single_empty_after", empty, 1'b1);
    chk("single_nlaunch", launched.size(), 1);
    chk("single_byte", launched[0], 8'hAB);

    // 3. burst order
    wr_en = 1'b1; wr_data = 8'h11;
    tick;
    chk("burst_count1", count, 5'd1);
    wr_data = 8'h22;
    tick;
    chk("burst_start11", tx_start, 1'b1);
    chk("burst_data11", tx_data_in, 8'h11);
    chk("burst_count_pp", count, 5'd1);
    wr_data = 8'h33; tx_busy = 1'b1;
    tick;
    chk("burst_peak", count, 5'd2);
    chk("burst_start_low", tx_start, 1'b0);
    wr_en = 1'b0;
    frame(8'h11, 2);
    tick;
    chk("burst_start22", tx_start, 1'b1);
    chk("burst_data22", tx_data_in, 8'h22);
    chk("burst_count_22", count, 5'd1);
    frame(8'h22, 2);
    tick;
    chk("burst_start33", tx_start, 1'b1);
    chk("burst_data33", tx_data_in, 8'h33);
    chk("burst_count_33", count, 5'd0);
    frame(8'h33, 2);
    tick;
    chk("burst_idle", tx_start, 1'b0);
    chk("burst_empty", empty, 1'b1);
    chk("burst_nlaunch", launched.size(), 4);
    chk("burst_b0", launched[1], 8'h11);
    chk("burst_b1", launched[2], 8'h22);
    chk("burst_b2", launched[3], 8'h33);

    // 4. overflow with transmitter held busy
    tx_busy = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick;
      chk("ovf_fill_count", count, 5'(i + 1));
    end
    chk("ovf_full", full, 1'b1);
    chk("ovf_no_drop_yet", drop, 1'b0);
    chk("ovf_no_launch", tx_start, 1'b0);
    wr_data = 8'hFF;
    tick;
    chk("ovf_drop1", drop, 1'b1);
    chk("ovf_count_held", count, 5'd16);
    tick;
    chk("ovf_drop2", drop, 1'b1);
    wr_en = 1'b0;
    tick;
    chk("ovf_drop_clear", drop, 1'b0);
    chk("ovf_count16", count, 5'd16);
    // pop and push in the same cycle while full: push still rejected
    tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    tick;
    chk("ovf_pp_drop", drop, 1'b1);
    chk("ovf_pp_count", count, 5'd15);
    chk("ovf_pp_full", full, 1'b0);
    chk("ovf_start0", tx_start, 1'b1);
    chk("ovf_data0", tx_data_in, 8'h00);
    wr_en = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      frame(8'(i), 2);
      tick;
      if (i < 15) begin
        chk("ovf_start", tx_start, 1'b1);
        chk("ovf_data", tx_data_in, 8'(i + 1));
        chk("ovf_count", count, 5'(14 - i));
      end else begin
        chk("ovf_drained_start", tx_start, 1'b0);
        chk("ovf_drained_empty", empty, 1'b1);
      end
    end
    chk("ovf_nlaunch", launched.size(), 20);
    for (int unsigned i = 0; i < 16; i++) begin
      chk("ovf_byte", launched[4 + i], 8'(i));
    end

    // 5. simultaneous push/pop at count == 1
    tx_busy = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick;
    chk("pp_count_pre", count, 5'd1);
    tx_busy = 1'b0; wr_data = 8'h5A;
    tick;
    chk("pp_count", count, 5'd1);
    chk("pp_start", tx_start, 1'b1);
    chk("pp_data", tx_data_in, 8'h77);
    wr_en = 1'b0;
    frame(8'h77, 2);
    tick;
    chk("pp_start_5a", tx_start, 1'b1);
    chk("pp_data_5a", tx_data_in, 8'h5A);
    chk("pp_count_0", count, 5'd0);
    frame(8'h5A, 2);
    tick;
    chk("pp_empty", empty, 1'b1);
    chk("pp_nlaunch", launched.size(), 22);

    // 6. reset while waiting for tx_done
    wr_en = 1'b1; wr_data = 8'hC3;
    tick;
    wr_data = 8'h3C;
    tick;
    chk("mid_start", tx_start, 1'b1);
    chk("mid_data", tx_data_in, 8'hC3);
    chk("mid_count", count, 5'd1);
    wr_en = 1'b0; tx_busy = 1'b1;
    tick;
    chk("mid_wait", tx_start, 1'b0);
    rst = 1'b1;
    tick;
    chk("mid_rst_count", count, 5'd0);
    chk("mid_rst_empty", empty, 1'b1);
    chk("mid_rst_full", full, 1'b0);
    chk("mid_rst_start", tx_start, 1'b0);
    chk("mid_rst_data", tx_data_in, 8'h00);
    chk("mid_rst_drop", drop, 1'b0);
    rst = 1'b0; tx_busy = 1'b0;
    n_before = launched.size();
    for (int unsigned i = 0; i < 12; i++) begin
      tick;
      chk("mid_quiet", tx_start, 1'b0);
    end
    chk("mid_nlaunch", launched.size(), n_before);
    wr_en = 1'b1; wr_data = 8'h99;
    tick;
    wr_en = 1'b0;
    tick;
    chk("mid_recover_start", tx_start, 1'b1);
    chk("mid_recover_data", tx_data_in, 8'h99);
    frame(8'h99, 2);
    tick;
    chk("mid_recover_empty", empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
